// File: rtl/pwm_pulse_decoder.sv
// Servo-style PWM receiver: measures high time and maps it to a 5-bit motor code.
// Includes glitch rejection, over-width fault strobe and loss-of-signal timeout.
module pwm_pulse_decoder #(
    parameter int unsigned CNT_W         = 21,
    parameter int unsigned GLITCH_TICKS  = 500,
    parameter int unsigned MIN_TICKS     = 50000,
    parameter int unsigned STEP_TICKS    = 1563,
    parameter int unsigned MAX_TICKS     = 105000,
    parameter int unsigned TIMEOUT_TICKS = 1250000,
    parameter logic [4:0]  SAFE_CODE     = 5'd16
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       PWM_IN,
    output logic [4:0] MC,
    output logic       MC_VALID,
    output logic       LINK_OK,
    output logic       ERR_WIDTH
);

    typedef enum logic [1:0] {WAIT_LOW, IDLE, HIGH} state_e;

    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
    localparam logic [CNT_W-1:0] GLITCH_C = CNT_W'(GLITCH_TICKS);
    localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_TICKS);
    localparam logic [CNT_W-1:0] STEP_L_C = CNT_W'(STEP_TICKS - 1);
    localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_TICKS);
    localparam logic [CNT_W-1:0] TO_C     = CNT_W'(TIMEOUT_TICKS);
    localparam logic [CNT_W-1:0] TO_M1_C  = CNT_W'(TIMEOUT_TICKS - 1);

    state_e           state_q, state_d;
    logic             s1_q, s2_q, s3_q;
    logic             rise_q, fall_q;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] step_q, step_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic [4:0]       code_q, code_d;
    logic [4:0]       mc_q, mc_d;
    logic             mcv_q, mcv_d;
    logic             link_q, link_d;
    logic             err_q, err_d;
    logic             pulse_ok;

    // Edge strobes are registered; s3 is the line level aligned with them.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_q   <= 1'b1;
            s2_q   <= 1'b1;
            s3_q   <= 1'b1;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= PWM_IN;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            rise_q <= s2_q & ~s3_q;
            fall_q <= ~s2_q & s3_q;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= WAIT_LOW;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WAIT_LOW: if (!s3_q) state_d = IDLE;
            IDLE:     if (rise_q) state_d = HIGH;
            HIGH: begin
                if (fall_q) state_d = IDLE;
                else if (hcnt_q == MAX_C) state_d = WAIT_LOW;
            end
            default:  state_d = WAIT_LOW;
        endcase
    end

    always_comb begin
        hcnt_d   = hcnt_q;
        step_d   = step_q;
        code_d   = code_q;
        mc_d     = mc_q;
        mcv_d    = 1'b0;
        link_d   = link_q;
        err_d    = 1'b0;
        pulse_ok = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rise_q) begin
                    hcnt_d = ONE_C;
                    step_d = '0;
                    code_d = 5'd0;
                end
            end
            HIGH: begin
                if (fall_q) begin
                    if (hcnt_q >= GLITCH_C) begin
                        pulse_ok = 1'b1;
                        mc_d     = (hcnt_q <= MIN_C) ? 5'd0 : code_q;
                    end
                end else if (hcnt_q == MAX_C) begin
                    err_d = 1'b1;
                end else if (s3_q) begin
                    hcnt_d = hcnt_q + ONE_C;
                    if (hcnt_q >= MIN_C) begin
                        if (step_q == STEP_L_C) begin
                            step_d = '0;
                            code_d = (code_q == 5'd31) ? code_q : code_q + 5'd1;
                        end else begin
                            step_d = step_q + ONE_C;
                        end
                    end
                end
            end
            default: ;
        endcase

        // A decoded pulse in the timeout cycle pre-empts the timeout.
        tcnt_d = (tcnt_q == TO_C) ? tcnt_q : tcnt_q + ONE_C;
        if (pulse_ok) begin
            tcnt_d = '0;
            mcv_d  = 1'b1;
            link_d = 1'b1;
        end else if (tcnt_q == TO_M1_C) begin
            mc_d   = SAFE_CODE;
            mcv_d  = 1'b1;
            link_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hcnt_q <= '0;
            step_q <= '0;
            code_q <= 5'd0;
            tcnt_q <= '0;
            mc_q   <= SAFE_CODE;
            mcv_q  <= 1'b0;
            link_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            hcnt_q <= hcnt_d;
            step_q <= step_d;
            code_q <= code_d;
            tcnt_q <= tcnt_d;
            mc_q   <= mc_d;
            mcv_q  <= mcv_d;
            link_q <= link_d;
            err_q  <= err_d;
        end
    end

    assign MC        = mc_q;
    assign MC_VALID  = mcv_q;
    assign LINK_OK   = link_q;
    assign ERR_WIDTH = err_q;

endmodule
